// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold values 0..WIDTH inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle between a requester and the shift-and-add multiplier.
interface shift_add_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_ctrl.sv
// Three-state controller for the shift-and-add multiplier: load, iterate, report.
module mult_ctrl
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic last,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0] state;
    logic [1:0] state_nx;

    // NOTE: every branch is covered by the default first line, so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    assign load   = (state == ST_IDLE) && start;
    assign step   = (state == ST_RUN);
    assign finish = (state == ST_RUN) && last;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock with early exit.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    shift_add_mult_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    logic             load, step, finish, last;
    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [PW-1:0]    mcand, acc, acc_sum;
    logic [WIDTH-1:0] mplier, mplier_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             neg;
    logic [PW-1:0]    product;

    mult_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.start),
        .last   (last),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (bus.busy),
        .done   (bus.done)
    );

    // The most-negative value negates to itself, which read unsigned is its true magnitude.
    assign signed_op = SIGNED_EN && bus.is_signed;
    assign mag_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
    assign mplier_nx = mplier >> 1;
    assign cnt_nx    = cnt + CW'(1);
    assign last      = (mplier_nx == '0) || (cnt_nx == CW'(WIDTH));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                mcand  <= PW'(mag_a);
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= '0;
                neg    <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end else if (step) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier_nx;
                cnt    <= cnt_nx;
            end
            // Negating zero yields zero, so no special case for a zero product.
            if (finish) product <= neg ? -acc_sum : acc_sum;
        end
    end

    assign bus.product = product;

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-and-add multiplier with its controller and datapath in one block. Accepts a pair of operands on a start pulse, retires one multiplier bit per clock, stops early once the remaining multiplier bits are zero, and presents a registered double-width product with a one-cycle done pulse. Sits wherever the design needs a low-area multiply; it is the generalised successor of the single-width load/shift multiplier controller.

## Interface
- WIDTH, 8: operand width in bits (≥2); product is 2*WIDTH.
- SIGNED_EN, 1: 1 = two's-complement mode selectable per operation; 0 = unsigned only, `is_signed` ignored.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  operands are two's complement; sampled with `start`.
- a  in  WIDTH  multiplicand; sampled with `start`.
- b  in  WIDTH  multiplier; sampled with `start`.
- busy  out  1  high in RUN and DONE.
- done  out  1  high for exactly the one cycle spent in DONE.
- product  out  2*WIDTH  result register; valid when `done` is high and held until the next DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, busy=0, done=0, product=0, all internal registers 0.
- IDLE: if start=1 → RUN; capture mcand=|a| zero-extended to 2*WIDTH, mplier=|b|, acc=0, cnt=0, neg=signed_op & (a[MSB]^b[MSB]), where signed_op = SIGNED_EN & is_signed. Magnitudes are taken only when signed_op=1; otherwise a, b are used as-is. Otherwise stay in IDLE.
- RUN, every cycle: if mplier[0] then acc += mcand (2*WIDTH, no overflow possible); mcand <<= 1; mplier >>= 1; cnt += 1.
- RUN exit to DONE on the same edge when the shifted mplier is zero or cnt+1 == WIDTH. On that edge product <= neg ? -acc_next : acc_next, where acc_next is the accumulator value including this cycle's add.
- DONE: done=1 for one cycle, then → IDLE unconditionally.
- The most-negative operand (-2^(WIDTH-1)) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. The most-negative² product is +2^(2*WIDTH-2) and must be correct.
- Sign-flip happens on the 2*WIDTH value. A zero product is never negated to a nonzero value.
- `start` in RUN or DONE is ignored; no queueing. Operands may change freely after the capture edge.

## Timing
- Number of RUN cycles n = max(1, index of highest set bit of the multiplier magnitude + 1), and n ≤ WIDTH.
- The start capture edge is E0. RUN occupies n cycles. DONE is entered on edge E_n, and done/product are visible in the cycle after E_n.
- Earliest back-to-back: `start` is accepted in the first IDLE cycle after DONE, so the issue interval is n+2 cycles.
- busy rises on E0 and falls on the edge leaving DONE.
- Reset in any state: on the next edge, state = IDLE and busy, done, product are all 0. The in-flight operation is discarded, and no done pulse is produced.
- No combinational path from inputs to outputs. All outputs are registered or decoded from state only.

## Structure
- Package `mult_pkg`: state enum typedef (IDLE, RUN, DONE), and a function returning the count width, $clog2(WIDTH+1).
- Sub-module `mult_ctrl`: the FSM. Inputs are start, last (mplier-next-zero or count-terminal) and rst. Outputs are load, step, finish, busy and done. The datapath (operand registers, adder, shifter, sign fix-up) stays in the top.

## Test plan
- WIDTH=8, unsigned, a=13, b=11 → n=4; done high exactly one cycle, with product=143 in the 5th cycle after E0.
- WIDTH=8, unsigned, a=255, b=255 → n=8, product=65025; busy high for 9 cycles.
- WIDTH=8, signed, a=-128, b=-128 → product=16384. Also signed a=-3, b=5 → product=0xFFF1 (−15), n=3.
- b=0 with a=200 → n=1, product=0, done one cycle later; signed a=-7, b=0 → product=0.
- Pulse start every cycle during a 13×11 operation → only one done, with product=143. Assert reset during RUN → next cycle busy=0, done=0, product=0, and no done pulse follows.
- SIGNED_EN=0, is_signed=1, a=0xFF, b=0x02 → product=510 (unsigned treatment).
